// File: rtl/ftb_update_ctrl.sv
// FTB update controller: buffers committed branch updates and replays each one
// into the FTB SRAM as a READ (way select) followed by a WRITE, arbitrating against lookups.
module ftb_update_ctrl #(
    parameter int DEPTH      = 4,
    parameter int WAYS       = 4,
    parameter int STARVE_MAX = 7,
    parameter int XLEN       = 32,
    parameter int INFO_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_upd_vld,
    output logic              o_upd_rdy,
    input  logic [XLEN-1:0]   i_upd_pc,
    input  logic [INFO_W-1:0] i_upd_info,
    input  logic              i_lookup_req,
    output logic              o_lookup_block,
    output logic              o_ftb_update_req,
    output logic [XLEN-1:0]   o_ftb_update_pc,
    input  logic [WAYS-1:0]   i_ftb_update_sel,
    output logic              o_ftb_write_req,
    output logic [WAYS-1:0]   o_ftb_write_way_vec,
    output logic [INFO_W-1:0] o_ftb_write_info,
    output logic              o_busy
);

    // state   | meaning
    // S_IDLE  | no SRAM access; waiting for an entry and an arbitration win
    // S_READ  | update index presented, SRAM resolves the target way
    // S_WRITE | index held, entry written into the selected way, head popped
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;

    logic [XLEN-1:0]   pc_mem_q   [DEPTH];
    logic [INFO_W-1:0] info_mem_q [DEPTH];

    logic empty, full, push, pop, starve_max, go_idle, go_post;

    always_comb begin
        state_d             = state_q;
        wr_ptr_d            = wr_ptr_q;
        rd_ptr_d            = rd_ptr_q;
        count_d             = count_q;
        starve_cnt_d        = starve_cnt_q;
        pop                 = 1'b0;
        o_ftb_update_req    = 1'b0;
        o_ftb_update_pc     = '0;
        o_ftb_write_req     = 1'b0;
        o_ftb_write_way_vec = '0;
        o_ftb_write_info    = '0;

        empty      = (count_q == '0);
        full       = (count_q == CW'(DEPTH));
        push       = i_upd_vld && !full;
        starve_max = (starve_cnt_q == SW'(STARVE_MAX));
        go_idle    = !empty && (!i_lookup_req || full || starve_max);
        // After the WRITE pop one entry has left, so the FIFO can never be full here.
        go_post    = (count_q > CW'(1)) && (!i_lookup_req || starve_max);

        unique case (state_q)
            S_IDLE: begin
                if (go_idle) state_d = S_READ;
            end
            S_READ: begin
                o_ftb_update_req = 1'b1;
                o_ftb_update_pc  = pc_mem_q[rd_ptr_q];
                state_d          = S_WRITE;
            end
            S_WRITE: begin
                o_ftb_update_req    = 1'b1;
                o_ftb_update_pc     = pc_mem_q[rd_ptr_q];
                o_ftb_write_req     = 1'b1;
                o_ftb_write_way_vec = i_ftb_update_sel;
                o_ftb_write_info    = info_mem_q[rd_ptr_q];
                pop                 = 1'b1;
                state_d             = go_post ? S_READ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (empty || (state_q == S_IDLE && go_idle))
            starve_cnt_d = '0;
        else if (state_q == S_IDLE && i_lookup_req && !starve_max)
            starve_cnt_d = starve_cnt_q + SW'(1);

        o_upd_rdy      = !full;
        o_busy         = !empty || (state_q != S_IDLE);
        o_lookup_block = o_ftb_update_req && i_lookup_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Payload storage needs no reset: outputs are gated by state and count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= i_upd_pc;
            info_mem_q[wr_ptr_q] <= i_upd_info;
        end
    end

    a_sel_onehot: assert property (@(posedge clk) disable iff (rst)
        (state_q == S_WRITE) |-> $onehot(i_ftb_update_sel));

endmodule

// File: tb/tb_ftb_update_ctrl.sv
// Bench for ftb_update_ctrl: queue-based reference model, FIFO-order scoreboard,
// small set-associative SRAM model supplying the way select.
module tb_ftb_update_ctrl;
    localparam int DEPTH = 4;
    localparam int WAYS  = 4;
    localparam int SMAX  = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_upd_vld;
    logic        o_upd_rdy;
    logic [31:0] i_upd_pc;
    logic [31:0] i_upd_info;
    logic        i_lookup_req;
    logic        o_lookup_block;
    logic        o_ftb_update_req;
    logic [31:0] o_ftb_update_pc;
    logic [3:0]  i_ftb_update_sel;
    logic        o_ftb_write_req;
    logic [3:0]  o_ftb_write_way_vec;
    logic [31:0] o_ftb_write_info;
    logic        o_busy;

    always #5 clk = ~clk;

    ftb_update_ctrl #(.DEPTH(DEPTH), .WAYS(WAYS), .STARVE_MAX(SMAX), .XLEN(32), .INFO_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_upd_vld(i_upd_vld), .o_upd_rdy(o_upd_rdy),
        .i_upd_pc(i_upd_pc), .i_upd_info(i_upd_info),
        .i_lookup_req(i_lookup_req), .o_lookup_block(o_lookup_block),
        .o_ftb_update_req(o_ftb_update_req), .o_ftb_update_pc(o_ftb_update_pc),
        .i_ftb_update_sel(i_ftb_update_sel),
        .o_ftb_write_req(o_ftb_write_req), .o_ftb_write_way_vec(o_ftb_write_way_vec),
        .o_ftb_write_info(o_ftb_write_info), .o_busy(o_busy)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] info;
    } ent_t;

    ent_t m_q[$];
    ent_t exp_q[$];
    int   m_phase;   // 0 idle, 1 read, 2 write (phase of the upcoming cycle)
    int   m_starve;
    int   total = 0;
    int   bad   = 0;

    logic s_rdy, s_wr, s_req, s_blk, s_busy;
    logic [3:0] wr_ways[$];

    // SRAM model: 16 sets indexed by pc[7:4], full pc as tag, round-robin victim.
    logic [31:0] tag_mem [16][4];
    logic        vld_mem [16][4];
    int          victim  [16];
    int          sram_gen = 0;

    function automatic logic [3:0] sram_sel(input logic [31:0] pc);
        int s;
        s = int'(pc[7:4]);
        for (int w = 0; w < 4; w++)
            if (vld_mem[s][w] && tag_mem[s][w] == pc) return 4'(1 << w);
        return 4'(1 << victim[s]);
    endfunction

    function automatic int count_tag(input logic [31:0] pc);
        int s, n;
        s = int'(pc[7:4]);
        n = 0;
        for (int w = 0; w < 4; w++)
            if (vld_mem[s][w] && tag_mem[s][w] == pc) n++;
        return n;
    endfunction

    task automatic sram_write(input logic [31:0] pc, input logic [3:0] vec);
        int s, way;
        logic hit;
        s   = int'(pc[7:4]);
        way = -1;
        hit = (count_tag(pc) != 0);
        for (int w = 3; w >= 0; w--) if (vec[w]) way = w;
        if (way >= 0) begin
            tag_mem[s][way] = pc;
            vld_mem[s][way] = 1'b1;
            if (!hit) victim[s] = (victim[s] + 1) % 4;
            sram_gen++;
        end
    endtask

    always @(o_ftb_update_pc or sram_gen) i_ftb_update_sel = sram_sel(o_ftb_update_pc);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every WRITE must carry the oldest outstanding update.
    always @(negedge clk) begin
        ent_t e;
        #2;
        if (o_ftb_write_req === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_write actual=%0h expected=none", o_ftb_update_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", 64'(o_ftb_update_pc), 64'(e.pc));
                chk("sb_info", 64'(o_ftb_write_info), 64'(e.info));
                chk("sb_way", 64'(o_ftb_write_way_vec), 64'(i_ftb_update_sel));
            end
            wr_ways.push_back(o_ftb_write_way_vec);
            sram_write(o_ftb_update_pc, o_ftb_write_way_vec);
        end
    end

    task automatic check_outputs();
        logic [31:0] e_pc;
        e_pc = (m_phase != 0) ? m_q[0].pc : 32'h0;
        chk("rdy", 64'(o_upd_rdy), 64'(m_q.size() != DEPTH));
        chk("busy", 64'(o_busy), 64'(m_q.size() != 0 || m_phase != 0));
        chk("upd_req", 64'(o_ftb_update_req), 64'(m_phase != 0));
        chk("upd_pc", 64'(o_ftb_update_pc), 64'(e_pc));
        chk("wr_req", 64'(o_ftb_write_req), 64'(m_phase == 2));
        chk("blk", 64'(o_lookup_block), 64'(m_phase != 0 && i_lookup_req));
        chk("way_vec", 64'(o_ftb_write_way_vec), 64'((m_phase == 2) ? i_ftb_update_sel : 4'h0));
        if (m_phase == 2) chk("wr_info", 64'(o_ftb_write_info), 64'(m_q[0].info));
    endtask

    task automatic model_step(input logic vld, input logic [31:0] pc, input logic [31:0] info,
                              input logic lk);
        ent_t e;
        int   n;
        logic acc;
        n   = m_q.size();
        acc = vld && (n != DEPTH);
        case (m_phase)
            0: begin
                if (n > 0 && (!lk || n == DEPTH || m_starve == SMAX)) begin
                    m_phase  = 1;
                    m_starve = 0;
                end else if (n > 0 && lk && m_starve < SMAX) begin
                    m_starve++;
                end
            end
            1: m_phase = 2;
            default: begin
                void'(m_q.pop_front());
                if (m_q.size() > 0 && (!lk || m_q.size() == DEPTH || m_starve == SMAX))
                    m_phase = 1;
                else
                    m_phase = 0;
            end
        endcase
        if (n == 0) m_starve = 0;
        if (acc) begin
            e.pc   = pc;
            e.info = info;
            m_q.push_back(e);
            exp_q.push_back(e);
        end
    endtask

    task automatic cycle(input logic vld, input logic [31:0] pc, input logic [31:0] info,
                         input logic lk);
        @(negedge clk);
        i_upd_vld    = vld;
        i_upd_pc     = pc;
        i_upd_info   = info;
        i_lookup_req = lk;
        #1;
        s_rdy  = o_upd_rdy;
        s_wr   = o_ftb_write_req;
        s_req  = o_ftb_update_req;
        s_blk  = o_lookup_block;
        s_busy = o_busy;
        check_outputs();
        @(posedge clk);
        model_step(vld, pc, info, lk);
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (m_q.size() == 0 && m_phase == 0) break;
            cycle(1'b0, 32'h0, 32'h0, 1'b0);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b0);
        chk("drain_busy", 64'(s_busy), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        logic prev_wr, acc_after_wr, found;
        logic [31:0] pcs [6];
        pcs[0] = 32'h1000; pcs[1] = 32'h2040; pcs[2] = 32'h5040;
        pcs[3] = 32'h3080; pcs[4] = 32'h2000; pcs[5] = 32'h7040;
        for (int s = 0; s < 16; s++) begin
            victim[s] = 0;
            for (int w = 0; w < 4; w++) begin
                vld_mem[s][w] = 1'b0;
                tag_mem[s][w] = '0;
            end
        end
        sram_gen++;
        m_phase = 0;
        m_starve = 0;

        rst = 1'b1;
        i_upd_vld = 1'b0; i_upd_pc = '0; i_upd_info = '0; i_lookup_req = 1'b1;
        #12;
        chk("rst_rdy", 64'(o_upd_rdy), 64'h1);
        chk("rst_busy", 64'(o_busy), 64'h0);
        chk("rst_upd_req", 64'(o_ftb_update_req), 64'h0);
        chk("rst_wr_req", 64'(o_ftb_write_req), 64'h0);
        chk("rst_blk", 64'(o_lookup_block), 64'h0);
        chk("rst_pc", 64'(o_ftb_update_pc), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // single update, no lookup contention
        cycle(1'b1, 32'h1000, 32'hAAAA_0001, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0);
        chk("t1_idle_busy", 64'(s_busy), 64'h1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0);
        chk("t1_read", 64'(s_req), 64'h1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0);
        chk("t1_write", 64'(s_wr), 64'h1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0);
        chk("t1_done_busy", 64'(s_busy), 64'h0);

        // starvation bound: READ exactly STARVE_MAX+1 cycles after the entry is visible
        cycle(1'b1, 32'h3000, 32'hBBBB_0002, 1'b1);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1);
            if (s_req) begin
                n = k;
                chk("starve_blk_read", 64'(s_blk), 64'h1);
                break;
            end
        end
        chk("starve_wait", 64'(n), 64'(SMAX + 2));
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        chk("starve_blk_write", 64'(s_blk), 64'h1);
        drain();

        // same pc back to back must land in the same way
        wr_ways.delete();
        cycle(1'b1, 32'h2040, 32'hCCCC_0003, 1'b0);
        cycle(1'b1, 32'h2040, 32'hCCCC_0004, 1'b0);
        drain();
        chk("same_pc_writes", 64'(wr_ways.size()), 64'h2);
        if (wr_ways.size() == 2) chk("same_pc_way", 64'(wr_ways[1]), 64'(wr_ways[0]));
        chk("same_pc_dup", 64'(count_tag(32'h2040)), 64'h1);

        // full FIFO with a push offered during the WRITE pop
        for (int k = 0; k < 4; k++) cycle(1'b1, 32'h4000 + 32'(k * 16), 32'hD000 + 32'(k), 1'b1);
        prev_wr = 1'b0; acc_after_wr = 1'b0; found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 32'h4550, 32'hEEEE_0005, 1'b1);
            if (s_rdy) begin
                acc_after_wr = prev_wr;
                found = 1'b1;
                break;
            end
            prev_wr = s_wr;
        end
        chk("full_push_found", 64'(found), 64'h1);
        chk("full_push_after_write", 64'(acc_after_wr), 64'h1);
        drain();

        // reset in the WRITE cycle with three entries queued
        for (int k = 0; k < 3; k++) cycle(1'b1, 32'h6000 + 32'(k * 16), 32'hF000 + 32'(k), 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (m_phase == 2) break;
            cycle(1'b0, 32'h0, 32'h0, 1'b1);
        end
        @(negedge clk);
        i_upd_vld = 1'b0;
        i_lookup_req = 1'b1;
        #1;
        chk("prerst_write", 64'(o_ftb_write_req), 64'h1);
        chk("prerst_count", 64'(m_q.size()), 64'h3);
        rst = 1'b1;
        #1;
        chk("arst_upd_req", 64'(o_ftb_update_req), 64'h0);
        chk("arst_wr_req", 64'(o_ftb_write_req), 64'h0);
        chk("arst_way", 64'(o_ftb_write_way_vec), 64'h0);
        chk("arst_info", 64'(o_ftb_write_info), 64'h0);
        chk("arst_blk", 64'(o_lookup_block), 64'h0);
        m_q.delete();
        exp_q.delete();
        m_phase = 0;
        m_starve = 0;
        #1;
        rst = 1'b0;
        #1;
        chk("postrst_rdy", 64'(o_upd_rdy), 64'h1);
        chk("postrst_busy", 64'(o_busy), 64'h0);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            cycle(1'($urandom_range(0, 1)), pcs[$urandom_range(0, 5)], $urandom,
                  1'($urandom_range(0, 9) < 7));
        end
        drain();
        chk("sb_left", 64'(exp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
